net_tx_feeder: RTL
==================

# net_tx_feeder

Byte-pacing stage directly upstream of `net_driver`. It accepts payload bytes from application logic over a valid/ready handshake and buffers them in a small FIFO. It then presents them one at a time on the driver's `data_in`/`flag` pair: byte held stable, one-cycle start pulse, then a fixed guard gap. The gap is needed because the W5500 path has no busy/done return. A post-reset hold-off covers the W5500 reset and initialisation.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, 50_000: idle cycles after each `flag` pulse (1 ms at 50 MHz); ≥1.
- `INIT_CYCLES`, 10_000_000: hold-off after reset before the first pulse (200 ms at 50 MHz); ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `data_out`  out  8  byte to `net_driver.data_in`; registered.
- `flag`  out  1  one-cycle start pulse to `net_driver.flag`; registered.
- `busy`  out  1  high when state ≠ IDLE or FIFO non-empty.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on an edge with `in_valid && in_ready`, `in_data` is written. Bytes are sent in FIFO order, with no drops and no duplicates.
- Pushes are accepted in every state, including INIT.
- States: INIT, IDLE, SETUP, FIRE, GAP.
- INIT: the counter runs `INIT_CYCLES` cycles, then goes to IDLE. No pops occur.
- IDLE: if the FIFO is non-empty, pop. `data_out <= head`, and the state goes to SETUP. Otherwise stay in IDLE.
- SETUP: one cycle. `data_out` is stable. The state goes to FIRE.
- FIRE: one cycle with `flag`=1. The state goes to GAP with the counter cleared.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE. `data_out` holds its value through GAP and until the next pop.
- Pop and push on the same edge (FIFO neither empty nor full) leave `fifo_count` unchanged. Both operations take effect.
- When full, `in_ready`=0. Push and pop on the same edge as the full condition is not permitted; `in_ready` depends only on the registered count.
- Counters are wide enough for `max(INIT_CYCLES, GAP_CYCLES)`. There is no wrap-around within a count.

## Timing
- Reset values, one edge after `rstn`=0: `flag`=0, `data_out`=8'h00, `fifo_count`=0, state INIT, counters 0.
- After reset, `in_ready`=1 and `busy`=1 (state is INIT).
- Reset mid-operation: FIFO contents are discarded. A `flag` that would have pulsed is suppressed. INIT restarts in full.
- Latency: push accepted at edge E0 with FIFO empty, state IDLE:
  - pop at E1;
  - `data_out` valid after E1;
  - `flag` high for the cycle after E2;
  - total of 2 cycles from acceptance to flag.
- `data_out` is stable for at least 1 cycle before, during, and `GAP_CYCLES` cycles after `flag`.
- Back-to-back bytes: `flag` rising edges are exactly `GAP_CYCLES+3` cycles apart.
- `flag` is never high in two consecutive cycles.
- First `flag` after reset: no earlier than `INIT_CYCLES+2` cycles after reset release.

## Structure
- Shared package `net_pkg` holds:
  - the state enum `feeder_state_t` (INIT, IDLE, SETUP, FIRE, GAP);
  - the default constants `NET_GAP_CYCLES` and `NET_INIT_CYCLES`, reused by `net_driver` integration.
- Sub-module `net_byte_fifo`: synchronous FIFO (8-bit, `DEPTH`). Ports are push/pop/data/count, and it is first-word-fall-through so `head` is readable in IDLE.
- The FSM and counters live in `net_tx_feeder`.

## Test plan
Bench parameters: `DEPTH`=4, `GAP_CYCLES`=4, `INIT_CYCLES`=10.
- Init hold-off: release reset, push 8'hA5 at cycle 0 → `flag` stays 0 through INIT. First `flag` at cycle 12, with `data_out`=8'hA5.
- Spacing and order: push 8'h01, 8'h02, 8'h03 after INIT → three `flag` pulses, each with the matching `data_out`, 7 cycles apart, each pulse 1 cycle wide.
- Full FIFO: during INIT, hold `in_valid`=1 with bytes 8'h10..8'h15 → `in_ready` drops after 4 accepts and `fifo_count`=4. Bytes 8'h10..8'h13 are sent in order; 8'h14 is accepted only after the first pop.
- Simultaneous push/pop: with `fifo_count`=2 in IDLE, push on the pop edge → `fifo_count` stays 2 and all bytes are delivered in order.
- Reset mid-GAP: assert `rstn`=0 for 1 cycle with 2 bytes queued → `fifo_count`=0, `flag`=0, `data_out`=8'h00. No `flag` until INIT completes again.
- Idle: no pushes after INIT → `flag`=0, `busy`=0 indefinitely, `data_out` holds its last value.

Source files
------------

// File: rtl/net_pkg.sv
// Shared types and default timing constants for the W5500 transmit path.
// Used by the feeder, its byte FIFO and the net_driver integration.
package net_pkg;

    typedef logic [7:0] net_byte_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_FIRE,
        ST_GAP
    } feeder_state_t;

    // 1 ms guard and 200 ms W5500 bring-up at 50 MHz
    localparam int NET_GAP_CYCLES  = 50_000;
    localparam int NET_INIT_CYCLES = 10_000_000;

    function automatic int net_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/net_byte_fifo.sv
// First-word-fall-through byte FIFO; head is valid whenever not empty.
// Overflowing pushes and underflowing pops are ignored.
module net_byte_fifo
    import net_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  net_byte_t                i_data,
    input  logic                     i_pop,
    output net_byte_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    net_byte_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/net_tx_feeder.sv
// Paces buffered bytes into net_driver: setup cycle, one-cycle flag,
// then a fixed guard gap, after a post-reset hold-off.
module net_tx_feeder
    import net_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int GAP_CYCLES  = NET_GAP_CYCLES,
    parameter int INIT_CYCLES = NET_INIT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               data_out,
    output logic                     flag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int MAX_CNT = net_max(INIT_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    feeder_state_t    r_state;
    feeder_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_flag;
    logic             w_flag_nxt;
    net_byte_t        r_data;
    net_byte_t        w_data_nxt;
    logic             w_pop;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    net_byte_t        w_head;

    assign w_push = in_valid && !w_full;

    net_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flag  <= w_flag_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_INIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: w_state_nxt = ST_FIRE;
            ST_FIRE: begin
                w_state_nxt = ST_GAP;
                w_cnt_nxt   = '0;
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Flag is registered from SETUP so it lands exactly on the FIRE cycle
    always_comb begin
        w_pop      = (r_state == ST_IDLE) && !w_empty;
        w_flag_nxt = (r_state == ST_SETUP);
        w_data_nxt = w_pop ? w_head : r_data;
    end

    assign in_ready = !w_full;
    assign data_out = r_data;
    assign flag     = r_flag;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

endmodule
